// File: rtl/led_blink_stretcher_pkg.sv
// led_blink_stretcher_pkg: shared FSM encoding and default blink timing for the candle LED path
package led_blink_stretcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int DEF_ON_CYCLES    = 50;
    localparam int DEF_OFF_CYCLES   = 50;
    localparam int DEF_PENDWIDTH    = 4;
    localparam int DEF_COUNTERWIDTH = 32;

endpackage

// File: rtl/led_blink_stretcher_sat.sv
// sat_updown_counter: saturating up/down counter with sync clear; flags an increment lost at full scale
module sat_updown_counter #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         drop_o
);

    logic [W-1:0] count_q, count_d;
    logic         drop_q, drop_d;
    logic         full, empty;

    assign full  = &count_q;
    assign empty = ~|count_q;

    // simultaneous inc and dec cancel, so a saturated counter never drops in that case
    always_comb begin
        count_d = (inc_i && !dec_i && !full)  ? count_q + 1'b1 :
                  (dec_i && !inc_i && !empty) ? count_q - 1'b1 : count_q;
        drop_d  = inc_i && !dec_i && full;
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    assign count_o = count_q;
    assign drop_o  = drop_q;

endmodule

// File: rtl/led_blink_stretcher.sv
// led_blink_stretcher: turns one-cycle event pulses into fixed-width LED blinks with a dark gap,
// queueing pulses that arrive mid-blink so every event yields exactly one blink
module led_blink_stretcher
    import led_blink_stretcher_pkg::*;
#(
    parameter int ON_CYCLES    = DEF_ON_CYCLES,
    parameter int OFF_CYCLES   = DEF_OFF_CYCLES,
    parameter int PENDWIDTH    = DEF_PENDWIDTH,
    parameter int COUNTERWIDTH = DEF_COUNTERWIDTH
) (
    input  logic                 clk_50MHz,
    input  logic                 rst,
    input  logic                 pulse_in,
    output logic                 led_out,
    output logic                 busy,
    output logic [PENDWIDTH-1:0] pending,
    output logic                 overflow
);

    localparam logic [COUNTERWIDTH-1:0] ON_LAST  = COUNTERWIDTH'(ON_CYCLES - 1);
    localparam logic [COUNTERWIDTH-1:0] OFF_LAST = COUNTERWIDTH'(OFF_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [COUNTERWIDTH-1:0] cnt_q, cnt_d;
    logic                    led_q, led_d;
    logic                    have_pend, launch, inc, dec;

    assign have_pend = |pending;
    assign launch    = (state_q == IDLE) && (have_pend || pulse_in);
    // a launch from IDLE consumes the queue first; a fresh pulse then joins the queue instead
    assign dec       = (state_q == IDLE) && have_pend;
    assign inc       = pulse_in && ((state_q != IDLE) || have_pend);

    sat_updown_counter #(
        .W(PENDWIDTH)
    ) u_pend (
        .clk_i  (clk_50MHz),
        .clr_i  (rst),
        .inc_i  (inc),
        .dec_i  (dec),
        .count_o(pending),
        .drop_o (overflow)
    );

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                state_d = launch ? ON : IDLE;
                cnt_d   = '0;
            end
            ON: begin
                state_d = (cnt_q == ON_LAST) ? GAP : ON;
                cnt_d   = (cnt_q == ON_LAST) ? '0 : cnt_q + 1'b1;
            end
            GAP: begin
                state_d = (cnt_q == OFF_LAST) ? IDLE : GAP;
                cnt_d   = (cnt_q == OFF_LAST) ? '0 : cnt_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        led_d = (state_d == ON);
        busy  = (state_q != IDLE);
    end

    assign led_out = led_q;

endmodule

// File: tb/tb_led_blink_stretcher.sv
// tb_led_blink_stretcher: three parameterisations checked every cycle against a blink-schedule model
module tb_led_blink_stretcher;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] pin;
    logic [2:0] led, busy, ovf;
    logic [3:0] p0, p2;
    logic [1:0] p1;

    always #10 clk = ~clk;

    led_blink_stretcher #(.ON_CYCLES(50), .OFF_CYCLES(50), .PENDWIDTH(4), .COUNTERWIDTH(32)) dut0 (
        .clk_50MHz(clk), .rst(rst), .pulse_in(pin[0]),
        .led_out(led[0]), .busy(busy[0]), .pending(p0), .overflow(ovf[0]));

    led_blink_stretcher #(.ON_CYCLES(50), .OFF_CYCLES(50), .PENDWIDTH(2), .COUNTERWIDTH(32)) dut1 (
        .clk_50MHz(clk), .rst(rst), .pulse_in(pin[1]),
        .led_out(led[1]), .busy(busy[1]), .pending(p1), .overflow(ovf[1]));

    led_blink_stretcher #(.ON_CYCLES(1), .OFF_CYCLES(1), .PENDWIDTH(4), .COUNTERWIDTH(32)) dut2 (
        .clk_50MHz(clk), .rst(rst), .pulse_in(pin[2]),
        .led_out(led[2]), .busy(busy[2]), .pending(p2), .overflow(ovf[2]));

    int onc[3]  = '{50, 50, 1};
    int offc[3] = '{50, 50, 1};
    int pmax[3] = '{15, 3, 15};
    int last[3], pend[3];
    bit act[3], movf[3];
    int cyc, total, bad;
    logic [255:0] pat;

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] cycle %0d: got %0d want %0d", tag, i, cyc, obs, exp);
        end
    endtask

    // model: a blink launched at edge L lights cycles L+1..L+ON and holds busy through L+ON+OFF
    task automatic tick();
        bit idle;
        logic [31:0] pg;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            idle    = !act[i] || (cyc >= last[i] + onc[i] + offc[i] + 1);
            movf[i] = 1'b0;
            if (rst) begin
                act[i]  = 1'b0;
                pend[i] = 0;
            end else if (idle && (pend[i] > 0 || pin[i])) begin
                if (pend[i] > 0 && !pin[i]) pend[i]--;
                act[i]  = 1'b1;
                last[i] = cyc;
            end else if (!idle && pin[i]) begin
                if (pend[i] == pmax[i]) movf[i] = 1'b1;
                else pend[i]++;
            end
        end
        cyc++;
        #1;
        for (int i = 0; i < 3; i++) begin
            pg = (i == 0) ? {28'd0, p0} : (i == 1) ? {30'd0, p1} : {28'd0, p2};
            chk("led", i, {31'd0, led[i]},
                {31'd0, act[i] && cyc >= last[i] + 1 && cyc <= last[i] + onc[i]});
            chk("busy", i, {31'd0, busy[i]},
                {31'd0, act[i] && cyc <= last[i] + onc[i] + offc[i]});
            chk("pending", i, pg, pend[i]);
            chk("overflow", i, {31'd0, ovf[i]}, {31'd0, movf[i]});
        end
    endtask

    task automatic run(input int n, input logic [2:0] mask);
        for (int t = 0; t < n; t++) begin
            pin = (t < 256 && pat[t]) ? mask : 3'b000;
            tick();
        end
        pin = 3'b000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pin = 3'b000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        for (int i = 0; i < 3; i++) begin
            act[i]  = 1'b0;
            pend[i] = 0;
            last[i] = 0;
            movf[i] = 1'b0;
        end
        rst = 1'b1;
        pin = 3'b000;
        do_reset();
        pat = '0; pat[0] = 1'b1;
        run(120, 3'b111);
        do_reset();
        pat = '0; pat[0] = 1'b1; pat[1] = 1'b1; pat[2] = 1'b1;
        run(320, 3'b111);
        do_reset();
        pat = '0; pat[0] = 1'b1; pat[10] = 1'b1; pat[11] = 1'b1; pat[12] = 1'b1; pat[13] = 1'b1;
        run(420, 3'b111);
        do_reset();
        pat = '0; pat[0] = 1'b1; pat[1] = 1'b1; pat[2] = 1'b1;
        run(20, 3'b111);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pat = '0;
        run(200, 3'b111);
        do_reset();
        pat = '0; pat[0] = 1'b1; pat[100] = 1'b1; pat[101] = 1'b1;
        run(320, 3'b111);
        do_reset();
        pat = '0; pat[0] = 1'b1; pat[1] = 1'b1;
        run(10, 3'b100);
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            rst = ($urandom_range(0, 399) == 0);
            pin = {$urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0};
            tick();
        end
        rst = 1'b0;
        pin = 3'b000;
        run(250, 3'b000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
